// File: rtl/core_mem_stage_p.sv
// Memory pipeline stage: ALU results pass to WB, loads/stores go to L1D by valid/ack request and valid response.
// Latency: 1 cycle for non-memory ops; memory ops take request-ack time plus response time, then 1 cycle to WB.
// Backpressure: mem_stall holds upstream from accept until completion; mem_enb=0 in IDLE holds WB. Optional MEM_MISALIGN_EXC_EN.
module core_mem_stage_p #(
    parameter int          XLEN     = 32,
    parameter int          RA_W     = 5,
    parameter logic [31:0] NC_BASE  = 32'hF000_0000,
    parameter logic [31:0] NC_LIMIT = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_enb,
    input  logic            mem_kill,
    input  logic            ex_val,
    input  logic            ex_ld,
    input  logic            ex_st,
    input  logic [1:0]      ex_size,
    input  logic            ex_sext,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic            ex_we,
    input  logic [RA_W-1:0] ex_rd,
    output logic            l1d_req_val,
    input  logic            l1d_req_ack,
    output logic [2:0]      l1d_req_cop,
    output logic [2:0]      l1d_req_size,
    output logic [XLEN-1:0] l1d_req_addr,
    output logic [3:0]      l1d_req_be,
    output logic [XLEN-1:0] l1d_req_wdata,
    input  logic            l1d_resp_val,
    input  logic [XLEN-1:0] l1d_resp_data,
    output logic            mem_stall,
    output logic            wb_val,
    output logic            wb_we,
    output logic [RA_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            mem_exc
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d, we_q, we_d, st_q, st_d, drop_q, drop_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    logic              wb_val_q, wb_val_d, wb_we_q, wb_we_d, exc_q, exc_d;
    logic [RA_W-1:0]   wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    logic              accept, is_mem, exc_take, mem_acc, in_req, nc_hit;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [XLEN-1:0]   ld_data;
    logic [3:0]        be;

    always_comb begin
        accept = (state_q == IDLE) && mem_enb && ex_val && !mem_kill;
        is_mem = ex_ld || ex_st;
`ifdef MEM_MISALIGN_EXC_EN
        exc_take = accept && is_mem &&
                   (((ex_size == 2'd1) && ex_addr[0]) || ((ex_size == 2'd2) && (ex_addr[1:0] != 2'b00)));
`else
        exc_take = 1'b0;
`endif
        mem_acc = accept && is_mem && !exc_take;
    end

    // Load lane extraction; misaligned halves/words naturally fall back to the aligned-down lane.
    always_comb begin
        lane_b = 8'h00;
        case (addr_q[1:0])
            2'd0: lane_b = l1d_resp_data[7:0];
            2'd1: lane_b = l1d_resp_data[15:8];
            2'd2: lane_b = l1d_resp_data[23:16];
            default: lane_b = l1d_resp_data[31:24];
        endcase
        lane_h = addr_q[1] ? l1d_resp_data[31:16] : l1d_resp_data[15:0];
        case (size_q)
            2'd0:    ld_data = {{24{sext_q & lane_b[7]}}, lane_b};
            2'd1:    ld_data = {{16{sext_q & lane_h[15]}}, lane_h};
            default: ld_data = l1d_resp_data;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    be = 4'b0001 << addr_q[1:0];
            2'd1:    be = 4'b0011 << {addr_q[1], 1'b0};
            default: be = 4'b1111;
        endcase
        in_req        = (state_q == REQ);
        nc_hit        = (addr_q >= NC_BASE) && (addr_q <= NC_LIMIT);
        l1d_req_val   = in_req;
        l1d_req_cop   = in_req ? {1'b0, nc_hit, st_q} : 3'b000;
        l1d_req_size  = in_req ? {1'b0, size_q} : 3'b000;
        l1d_req_addr  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
        l1d_req_be    = in_req ? be : 4'b0000;
        l1d_req_wdata = '0;
        if (in_req) begin
            case (size_q)
                2'd0:    l1d_req_wdata = {4{wdata_q[7:0]}};
                2'd1:    l1d_req_wdata = {2{wdata_q[15:0]}};
                default: l1d_req_wdata = wdata_q;
            endcase
        end
        mem_stall = (state_q != IDLE) || mem_acc;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        sext_d    = sext_q;
        we_d      = we_q;
        st_d      = st_q;
        rd_d      = rd_q;
        drop_d    = drop_q;
        wb_val_d  = 1'b0;
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        exc_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!mem_enb && !mem_kill) begin
                    wb_val_d = wb_val_q;
                    wb_we_d  = wb_we_q;
                end else if (exc_take) begin
                    wb_val_d = 1'b1;
                    exc_d    = 1'b1;
                end else if (mem_acc) begin
                    addr_d  = ex_addr;
                    wdata_d = ex_wdata;
                    size_d  = ex_size;
                    sext_d  = ex_sext;
                    we_d    = ex_we;
                    st_d    = ex_st;
                    rd_d    = ex_rd;
                    drop_d  = 1'b0;
                    state_d = REQ;
                end else if (accept) begin
                    wb_val_d  = 1'b1;
                    wb_we_d   = ex_we;
                    wb_rd_d   = ex_rd;
                    wb_data_d = ex_addr;
                end
            end
            REQ: begin
                // An ack wins over a same-cycle kill: the access is already committed at L1D.
                if (l1d_req_ack) begin
                    if (st_q) begin
                        state_d  = IDLE;
                        wb_val_d = !mem_kill;
                        wb_rd_d  = rd_q;
                    end else begin
                        state_d = RESP;
                        drop_d  = mem_kill;
                    end
                end else if (mem_kill) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (l1d_resp_val) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!drop_q && !mem_kill) begin
                        wb_val_d  = 1'b1;
                        wb_we_d   = we_q;
                        wb_rd_d   = rd_q;
                        wb_data_d = ld_data;
                    end
                end else if (mem_kill) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= 2'd0;
            sext_q    <= 1'b0;
            we_q      <= 1'b0;
            st_q      <= 1'b0;
            rd_q      <= '0;
            drop_q    <= 1'b0;
            wb_val_q  <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            sext_q    <= sext_d;
            we_q      <= we_d;
            st_q      <= st_d;
            rd_q      <= rd_d;
            drop_q    <= drop_d;
            wb_val_q  <= wb_val_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            exc_q     <= exc_d;
        end
    end

    assign wb_val  = wb_val_q;
    assign wb_we   = wb_we_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;
`ifdef MEM_MISALIGN_EXC_EN
    assign mem_exc = exc_q;
`else
    assign mem_exc = 1'b0;
`endif

endmodule

// File: tb/tb_core_mem_stage_p.sv
// Directed bench for core_mem_stage_p: hand-computed vectors for ALU, load, store, kill, reset and misalignment.
module tb_core_mem_stage_p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_enb, mem_kill, ex_val, ex_ld, ex_st, ex_sext, ex_we;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        l1d_req_val, l1d_req_ack, l1d_resp_val;
    logic [2:0]  l1d_req_cop, l1d_req_size;
    logic [31:0] l1d_req_addr, l1d_req_wdata, l1d_resp_data;
    logic [3:0]  l1d_req_be;
    logic        mem_stall, wb_val, wb_we, mem_exc;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_chk  = 0;
    int n_pass = 0;

    core_mem_stage_p dut (
        .clk(clk), .rst_n(rst_n), .mem_enb(mem_enb), .mem_kill(mem_kill),
        .ex_val(ex_val), .ex_ld(ex_ld), .ex_st(ex_st), .ex_size(ex_size),
        .ex_sext(ex_sext), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_we(ex_we),
        .ex_rd(ex_rd), .l1d_req_val(l1d_req_val), .l1d_req_ack(l1d_req_ack),
        .l1d_req_cop(l1d_req_cop), .l1d_req_size(l1d_req_size),
        .l1d_req_addr(l1d_req_addr), .l1d_req_be(l1d_req_be),
        .l1d_req_wdata(l1d_req_wdata), .l1d_resp_val(l1d_resp_val),
        .l1d_resp_data(l1d_resp_data), .mem_stall(mem_stall), .wb_val(wb_val),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mem_exc(mem_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        mem_enb = 1'b1; mem_kill = 1'b0; ex_val = 1'b0; ex_ld = 1'b0; ex_st = 1'b0;
        ex_size = 2'd0; ex_sext = 1'b0; ex_addr = '0; ex_wdata = '0; ex_we = 1'b0;
        ex_rd = '0; l1d_req_ack = 1'b0; l1d_resp_val = 1'b0; l1d_resp_data = '0;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input logic we, input logic [4:0] rd);
        ex_val = 1'b1; ex_ld = ld; ex_st = st; ex_size = sz; ex_sext = sx;
        ex_addr = a; ex_wdata = wd; ex_we = we; ex_rd = rd;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wb_val"}, wb_val, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        chk({tag, "_req_val"}, l1d_req_val, 0);
        chk({tag, "_stall"}, mem_stall, 0);
        chk({tag, "_exc"}, mem_exc, 0);
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        // ALU ops with mem_enb 1,0,1
        issue(0, 0, 2'd2, 0, 32'h0000_1234, 0, 1, 5'd5);
        #1 chk("alu_stall", mem_stall, 0);
        tick();
        chk("alu1_val", wb_val, 1); chk("alu1_we", wb_we, 1);
        chk("alu1_rd", wb_rd, 5);   chk("alu1_data", wb_data, 32'h0000_1234);
        mem_enb = 1'b0; ex_addr = 32'h0000_5555; ex_rd = 5'd6;
        tick();
        chk("hold_val", wb_val, 1); chk("hold_data", wb_data, 32'h0000_1234); chk("hold_rd", wb_rd, 5);
        mem_enb = 1'b1;
        tick();
        chk("alu2_data", wb_data, 32'h0000_5555); chk("alu2_rd", wb_rd, 6); chk("alu2_stall", mem_stall, 0);

        // LB sext at 0x103
        issue(1, 0, 2'd0, 1, 32'h0000_0103, 0, 1, 5'd7);
        #1 chk("lb_stall_acc", mem_stall, 1);
        tick();
        idle_in();
        #1;
        chk("lb_req_val", l1d_req_val, 1); chk("lb_be", l1d_req_be, 4'b1000);
        chk("lb_cop", l1d_req_cop, 3'b000); chk("lb_addr", l1d_req_addr, 32'h0000_0100);
        chk("lb_size", l1d_req_size, 3'd0); chk("lb_wbv_req", wb_val, 0);
        l1d_req_ack = 1'b1;
        tick();
        l1d_req_ack = 1'b0;
        chk("lb_resp_req_val", l1d_req_val, 0); chk("lb_resp_stall", mem_stall, 1);
        l1d_resp_val = 1'b1; l1d_resp_data = 32'h80AA_BB11;
        tick();
        l1d_resp_val = 1'b0;
        chk("lb_wb_val", wb_val, 1); chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_wb_rd", wb_rd, 7);   chk("lb_wb_we", wb_we, 1);
        tick();
        chk("lb_wb_once", wb_val, 0);

        // LHU at 0x102
        issue(1, 0, 2'd1, 0, 32'h0000_0102, 0, 1, 5'd8);
        tick();
        idle_in();
        #1 chk("lh_be", l1d_req_be, 4'b1100);
        l1d_req_ack = 1'b1;
        tick();
        l1d_req_ack = 1'b0; l1d_resp_val = 1'b1; l1d_resp_data = 32'h80AA_BB11;
        tick();
        l1d_resp_val = 1'b0;
        chk("lhu_wb_data", wb_data, 32'h0000_80AA);

        // SH uncached, ack delayed 3 cycles
        issue(0, 1, 2'd1, 0, 32'hF000_0002, 32'h1234_ABCD, 0, 5'd0);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sh_hold%0d_val", i), l1d_req_val, 1);
            chk($sformatf("sh_hold%0d_stall", i), mem_stall, 1);
            tick();
        end
        chk("sh_val", l1d_req_val, 1); chk("sh_cop", l1d_req_cop, 3'b011);
        chk("sh_be", l1d_req_be, 4'b1100); chk("sh_wdata", l1d_req_wdata, 32'hABCD_ABCD);
        chk("sh_addr", l1d_req_addr, 32'hF000_0000); chk("sh_stall", mem_stall, 1);
        l1d_req_ack = 1'b1;
        tick();
        l1d_req_ack = 1'b0;
        chk("sh_wb_val", wb_val, 1); chk("sh_wb_we", wb_we, 0);
        chk("sh_done_req", l1d_req_val, 0); chk("sh_done_stall", mem_stall, 0);

        // LW 0x40 killed in RESP
        issue(1, 0, 2'd2, 0, 32'h0000_0040, 0, 1, 5'd3);
        tick();
        idle_in();
        l1d_req_ack = 1'b1;
        tick();
        l1d_req_ack = 1'b0; mem_kill = 1'b1;
        tick();
        mem_kill = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("kill_resp_stall", mem_stall, 1);
        l1d_resp_val = 1'b1; l1d_resp_data = 32'h1111_2222;
        tick();
        l1d_resp_val = 1'b0;
        chk("kill_wb_val", wb_val, 0); chk("kill_idle_stall", mem_stall, 0);
        issue(0, 0, 2'd2, 0, 32'h0000_BEEF, 0, 1, 5'd9);
        tick();
        idle_in();
        chk("post_kill_val", wb_val, 1); chk("post_kill_data", wb_data, 32'h0000_BEEF);

        // Kill in REQ before ack
        issue(1, 0, 2'd2, 0, 32'h0000_0080, 0, 1, 5'd4);
        tick();
        idle_in();
        mem_kill = 1'b1;
        tick();
        mem_kill = 1'b0;
        chk("kreq_req_val", l1d_req_val, 0); chk("kreq_wb_val", wb_val, 0);
        chk("kreq_stall", mem_stall, 0);

        // Misaligned LW 0x41
        issue(1, 0, 2'd2, 0, 32'h0000_0041, 0, 1, 5'd2);
        tick();
        idle_in();
`ifdef MEM_MISALIGN_EXC_EN
        chk("mis_req_val", l1d_req_val, 0); chk("mis_exc", mem_exc, 1);
        chk("mis_wb_val", wb_val, 1);       chk("mis_wb_we", wb_we, 0);
        tick();
        chk("mis_exc_once", mem_exc, 0); chk("mis_req_after", l1d_req_val, 0);
`else
        chk("mis_req_val", l1d_req_val, 1); chk("mis_addr", l1d_req_addr, 32'h0000_0040);
        chk("mis_be", l1d_req_be, 4'b1111); chk("mis_exc", mem_exc, 0);
        l1d_req_ack = 1'b1;
        tick();
        l1d_req_ack = 1'b0; l1d_resp_val = 1'b1; l1d_resp_data = 32'hCAFE_F00D;
        tick();
        l1d_resp_val = 1'b0;
        chk("mis_wb_data", wb_data, 32'hCAFE_F00D);
`endif

        // Reset while a load is outstanding
        tick();
        issue(1, 0, 2'd2, 0, 32'h0000_0200, 0, 1, 5'd1);
        tick();
        idle_in();
        l1d_req_ack = 1'b1;
        tick();
        l1d_req_ack = 1'b0;
        chk("rst_pre_stall", mem_stall, 1);
        rst_n = 1'b0;
        #1 check_zero("rst_resp");
        @(negedge clk); rst_n = 1'b1;
        l1d_resp_val = 1'b1; l1d_resp_data = 32'h5A5A_5A5A;
        tick();
        l1d_resp_val = 1'b0;
        chk("stray_wb_val", wb_val, 0); chk("stray_stall", mem_stall, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
